// File: rtl/ina_poller_pkg.sv
// Shared constants for the INA sensor poller: FSM encoding, INA register
// pointers and the counter-width helper.
package ina_poller_pkg;

  typedef enum logic [3:0] {
    INA_IDLE     = 4'd0,
    INA_CFG      = 4'd1,
    INA_RD_SHUNT = 4'd2,
    INA_RD_BUS   = 4'd3,
    INA_RD_CUR   = 4'd4,
    INA_WAIT     = 4'd5,
    INA_PUBLISH  = 4'd6,
    INA_DELAY    = 4'd7
  } ina_state_t;

  localparam logic [7:0] INA_PTR_CONFIG  = 8'h00;
  localparam logic [7:0] INA_PTR_SHUNT   = 8'h01;
  localparam logic [7:0] INA_PTR_BUS     = 8'h02;
  localparam logic [7:0] INA_PTR_CURRENT = 8'h04;

  // Width that holds the larger of the delay and timeout cycle counts.
  function automatic int ina_cnt_width(input int poll_div, input int timeout);
    int m;
    m = (poll_div > timeout) ? poll_div : timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ina_timer.sv
// Saturating down-counter shared by the transaction timeout and the
// inter-round delay. expired is high while the count sits at zero.
module ina_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; otherwise count toward zero and hold there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ina_poller.sv
// Periodic INA power-monitor poller: configures the sensor once per enable
// session, then repeatedly reads shunt, bus and current registers through an
// external I2C master and publishes them as a coherent triple.
module ina_poller
  import ina_poller_pkg::*;
#(
  parameter logic [6:0]  SLV_ADDR  = 7'h40,
  parameter logic [15:0] CFG_VALUE = 16'h399F,
  parameter int          POLL_DIV  = 100000,
  parameter int          TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        err_clr,
  output logic        mst_start,
  output logic        mst_rd_wr,
  output logic [6:0]  mst_slv_addr,
  output logic [7:0]  mst_pointer,
  output logic [15:0] mst_wdata,
  input  logic [15:0] mst_rdata,
  input  logic        mst_eot,
  output logic [15:0] shunt_v,
  output logic [15:0] bus_v,
  output logic [15:0] current,
  output logic        sample_valid,
  output logic        busy,
  output logic        err
);

  localparam int CNT_W = ina_cnt_width(POLL_DIV, TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(POLL_DIV - 1);

  ina_state_t state_q, state_d;
  ina_state_t op_q;
  logic       eot_p0;
  logic       eot_rise;
  logic       done;
  logic       timeout;
  logic       tmr_load;
  logic       tmr_en;
  logic       tmr_expired;
  logic [CNT_W-1:0] tmr_load_val;
  logic [15:0] stg_shunt;
  logic [15:0] stg_bus;

  // A level left high by the previous transfer must not look like completion.
  assign eot_rise     = mst_eot & ~eot_p0;
  assign done         = (state_q == INA_WAIT) && eot_rise;
  assign timeout      = (state_q == INA_WAIT) && !eot_rise && tmr_expired;
  assign mst_slv_addr = SLV_ADDR;

  ina_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .enable   (tmr_en),
    .expired  (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= INA_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; WAIT returns to the sequence position held in op_q.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INA_IDLE:     if (enable) state_d = INA_CFG;
      INA_CFG,
      INA_RD_SHUNT,
      INA_RD_BUS,
      INA_RD_CUR:   state_d = INA_WAIT;
      INA_WAIT: begin
        if (done) begin
          case (op_q)
            INA_CFG:      state_d = INA_RD_SHUNT;
            INA_RD_SHUNT: state_d = INA_RD_BUS;
            INA_RD_BUS:   state_d = INA_RD_CUR;
            default:      state_d = INA_PUBLISH;
          endcase
        end else if (timeout) begin
          state_d = INA_DELAY;
        end
      end
      INA_PUBLISH:  state_d = INA_DELAY;
      INA_DELAY:    if (tmr_expired) state_d = enable ? INA_RD_SHUNT : INA_IDLE;
      default:      state_d = INA_IDLE;
    endcase
  end

  // Moore outputs and timer control.
  always_comb begin
    mst_start    = 1'b0;
    sample_valid = 1'b0;
    busy         = (state_q != INA_IDLE);
    tmr_load     = 1'b0;
    tmr_load_val = DLY_LOAD;
    tmr_en       = 1'b0;
    case (state_q)
      INA_CFG, INA_RD_SHUNT, INA_RD_BUS, INA_RD_CUR: begin
        mst_start    = 1'b1;
        tmr_load     = 1'b1;
        tmr_load_val = TMO_LOAD;
      end
      INA_WAIT: begin
        tmr_en   = 1'b1;
        tmr_load = timeout;
      end
      INA_PUBLISH: begin
        sample_valid = 1'b1;
        tmr_load     = 1'b1;
      end
      INA_DELAY:   tmr_en = 1'b1;
      default: ;
    endcase
  end

  // Transaction descriptor, latched on entry to an issuing state and held
  // until the next one so the master sees stable fields throughout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= INA_IDLE;
      mst_rd_wr   <= 1'b0;
      mst_pointer <= 8'h00;
      mst_wdata   <= 16'h0000;
    end else begin
      case (state_d)
        INA_CFG: begin
          op_q <= INA_CFG;      mst_rd_wr <= 1'b0;
          mst_pointer <= INA_PTR_CONFIG; mst_wdata <= CFG_VALUE;
        end
        INA_RD_SHUNT: begin
          op_q <= INA_RD_SHUNT; mst_rd_wr <= 1'b1;
          mst_pointer <= INA_PTR_SHUNT;  mst_wdata <= 16'h0000;
        end
        INA_RD_BUS: begin
          op_q <= INA_RD_BUS;   mst_rd_wr <= 1'b1;
          mst_pointer <= INA_PTR_BUS;    mst_wdata <= 16'h0000;
        end
        INA_RD_CUR: begin
          op_q <= INA_RD_CUR;   mst_rd_wr <= 1'b1;
          mst_pointer <= INA_PTR_CURRENT; mst_wdata <= 16'h0000;
        end
        default: ;
      endcase
    end
  end

  // Edge register for completion detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) eot_p0 <= 1'b0;
    else     eot_p0 <= mst_eot;
  end

  // Staging and publish. The triple is copied on the edge that enters
  // PUBLISH, taking the current reading straight from the master, so the
  // outputs are already valid in the cycle sample_valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_shunt <= 16'h0000;
      stg_bus   <= 16'h0000;
      shunt_v   <= 16'h0000;
      bus_v     <= 16'h0000;
      current   <= 16'h0000;
    end else begin
      if (done && (op_q == INA_RD_SHUNT)) stg_shunt <= mst_rdata;
      if (done && (op_q == INA_RD_BUS))   stg_bus   <= mst_rdata;
      if (done && (op_q == INA_RD_CUR)) begin
        shunt_v <= stg_shunt;
        bus_v   <= stg_bus;
        current <= mst_rdata;
      end
      if (timeout) begin
        stg_shunt <= 16'h0000;
        stg_bus   <= 16'h0000;
      end
    end
  end

  // Sticky error; a timeout wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (timeout) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

endmodule
